// File: rtl/n_bit_2_input_mux.sv
// N-bit 2:1 mux with a registered, load-enabled copy of the result and a sel-toggle flag.
// Latency: out 0 cycles, out_q and sel_changed 1 cycle; no backpressure, en only gates the out_q load.
module n_bit_2_input_mux #(
    parameter int WIDTH = 16
) (
    output logic [WIDTH-1:0] out,
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_changed
);

    logic sel_q;

    // The ?: operator merges a and b bitwise when sel is unknown, so agreeing bits stay known.
    assign out = sel ? b : a;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= '0;
        end else if (en) begin
            out_q <= out;
        end
    end

    // sel_q tracks sel every cycle regardless of en, so the flag reflects sel alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q       <= 1'b0;
            sel_changed <= 1'b0;
        end else begin
            sel_q       <= sel;
            sel_changed <= (sel != sel_q);
        end
    end

endmodule

// File: tb/tb_n_bit_2_input_mux.sv
// Self-checking bench for n_bit_2_input_mux: directed cases plus randomized traffic
// checked against a sample-history reference model.
module tb_n_bit_2_input_mux;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         sel;
    logic         en;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic [W-1:0] out_q;
    logic         sel_changed;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: expected registered value, expected flag, and the sel values
    // sampled at each edge since the last reset.
    logic [W-1:0] m_q;
    logic         m_chg;
    bit           sel_hist[$];

    always #5 clk = ~clk;

    n_bit_2_input_mux #(.WIDTH(W)) dut (
        .out         (out),
        .sel         (sel),
        .a           (a),
        .b           (b),
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .out_q       (out_q),
        .sel_changed (sel_changed)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q   = '0;
        m_chg = 1'b0;
        sel_hist.delete();
    endtask

    // Sel "changed" means the newest sample differs from the one before it
    // (an empty history counts as a previous sample of 0).
    task automatic edge_and_check(input string tag);
        bit prev;
        @(posedge clk);
        prev = (sel_hist.size() == 0) ? 1'b0 : sel_hist[sel_hist.size()-1];
        sel_hist.push_back(sel);
        if (sel_hist.size() > 4) void'(sel_hist.pop_front());
        m_chg = (sel_hist[sel_hist.size()-1] != prev);
        if (en) m_q = sel ? b : a;
        #1;
        chk({tag, "_q"},   32'(out_q),       32'(m_q));
        chk({tag, "_chg"}, 32'(sel_changed), 32'(m_chg));
    endtask

    task automatic comb_check(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                              input logic ts, input logic [W-1:0] exp);
        a = ta; b = tb_; sel = ts;
        #1;
        chk(tag, 32'(out), 32'(exp));
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; en = 1'b0; a = '0; b = '0;
        model_reset();
        #2;
        chk("rst_q",   32'(out_q),       32'h0);
        chk("rst_chg", 32'(sel_changed), 32'h0);

        // Combinational path, exercised while reset is held to show out ignores it.
        comb_check("c_ffff_s0", 16'hFFFF, 16'h0000, 1'b0, 16'hFFFF);
        comb_check("c_ffff_s1", 16'hFFFF, 16'h0000, 1'b1, 16'h0000);
        comb_check("c_abcd_s0", 16'hABCD, 16'hDCBA, 1'b0, 16'hABCD);
        comb_check("c_abcd_s1", 16'hABCD, 16'hDCBA, 1'b1, 16'hDCBA);
        comb_check("c_0101_s0", 16'h0101, 16'h5985, 1'b0, 16'h0101);
        comb_check("c_0101_s1", 16'h0101, 16'h5985, 1'b1, 16'h5985);

        @(negedge clk);
        sel = 1'b0; a = '0; b = '0;
        reset = 1'b0;

        // Load-enable behaviour.
        @(negedge clk);
        en = 1'b1; a = 16'h1234; sel = 1'b0;
        edge_and_check("reg_load");
        chk("reg_load_val", 32'(out_q), 32'h1234);
        @(negedge clk);
        en = 1'b0; a = 16'h5678;
        repeat (3) edge_and_check("reg_hold");
        chk("reg_hold_val", 32'(out_q), 32'h1234);

        // Select tracker: one-cycle pulse on a single rise.
        @(negedge clk);
        reset = 1'b1; model_reset();
        #1 reset = 1'b0;
        sel = 1'b0;
        repeat (2) edge_and_check("trk_low");
        chk("trk_low_val", 32'(sel_changed), 32'h0);
        @(negedge clk);
        sel = 1'b1;
        edge_and_check("trk_rise");
        chk("trk_rise_val", 32'(sel_changed), 32'h1);
        edge_and_check("trk_hold1");
        chk("trk_hold1_val", 32'(sel_changed), 32'h0);
        edge_and_check("trk_hold2");

        // Toggling every cycle keeps the flag high.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sel = ~sel;
            edge_and_check("trk_toggle");
            chk("trk_toggle_val", 32'(sel_changed), 32'h1);
        end

        // Asynchronous reset between edges with out_q=ABCD and the flag set.
        @(negedge clk);
        reset = 1'b1; model_reset();
        #1 reset = 1'b0;
        sel = 1'b0;
        edge_and_check("ar_pre");
        @(negedge clk);
        sel = 1'b1; en = 1'b1; a = 16'h1111; b = 16'hABCD;
        edge_and_check("ar_load");
        chk("ar_load_val", 32'(out_q), 32'hABCD);
        chk("ar_load_chg", 32'(sel_changed), 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("ar_q",   32'(out_q),       32'h0);
        chk("ar_chg", 32'(sel_changed), 32'h0);
        chk("ar_out", 32'(out),         32'hABCD);
        model_reset();
        @(negedge clk);
        reset = 1'b0; en = 1'b0;
        // sel is still 1, so the first post-reset edge must raise the flag.
        edge_and_check("ar_first");
        chk("ar_first_chg", 32'(sel_changed), 32'h1);
        chk("ar_first_q",   32'(out_q),       32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            a   = W'($urandom);
            b   = W'($urandom);
            en  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) sel = ~sel;
            #1;
            chk("rnd_out", 32'(out), 32'(sel ? b : a));
            edge_and_check("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/n_bit_2_input_mux.md
# n_bit_2_input_mux

Parameterised N-bit 2:1 multiplexer used wherever the datapath steers between two equal-width buses. The combinational output `out` selects `a` when `sel`=0 and `b` when `sel`=1, with no latency. A clocked side-stage adds two outputs: `out_q`, a registered copy of the selection with a load enable, and `sel_changed`, a one-cycle flag raised after `sel` toggles. Together these let downstream logic take a timing-clean, glitch-free version of the mux output.

## Interface
- `WIDTH`, default 16: bit width of `a`, `b`, `out` and `out_q`. Legal range is ≥1.
- `clk`  input  1: system clock. All register updates occur on the rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `out`  output  WIDTH: combinational mux result.
- `sel`  input  1: select. 0 selects `a`; 1 selects `b`.
- `a`  input  WIDTH: data input 0.
- `b`  input  WIDTH: data input 1.
- `en`  input  1: load enable for `out_q`.
- `out_q`  output  WIDTH: registered mux result.
- `sel_changed`  output  1: one-cycle pulse indicating that `sel` toggled.
- Declaration (positional) order is fixed as: `out`, `sel`, `a`, `b`, `clk`, `reset`, `en`, `out_q`, `sel_changed`. This keeps existing 4-port positional instances valid for the first four connections.

## Operation
- `out` = `sel` ? `b` : `a`.
  - Purely combinational and bitwise. There is no arithmetic and no width conversion.
- `out_q` register:
  - On a rising `clk` edge with `en`=1: `out_q` ← current `out`.
  - With `en`=0: `out_q` holds its value.
- Select tracker:
  - An internal register `sel_q` loads `sel` on every rising edge, independent of `en`.
  - `sel_changed` is registered: at each rising edge, `sel_changed` ← (`sel` != `sel_q`).
- Reset (asynchronous, immediate on `reset`=1, no clock needed):
  - `out_q` = 0, `sel_q` = 0, `sel_changed` = 0.
  - `out` is unaffected by reset and continues to follow its inputs.
- Reset mid-operation:
  - Registers clear immediately.
  - The first rising edge after deassertion behaves as if `sel_q`=0. A `sel`=1 present at that edge therefore produces `sel_changed`=1 on the following cycle.
- Simultaneous events:
  - If `sel` and the data inputs change in the same cycle, `out_q` captures the value selected by the new `sel` at the edge.
- Unknown `sel` (X/Z): `out` bits where `a` and `b` agree take that value; other bits are X. No synthesis requirement applies.
- There is no state machine.

## Timing
- `out`: zero-cycle combinational path from `sel`, `a` and `b`.
- `out_q`: 1-cycle latency from `out` when `en`=1.
- `sel_changed`:
  - Asserted for exactly one cycle, during the cycle after the edge at which a new `sel` value is first sampled.
  - A `sel` that toggles every cycle keeps `sel_changed` high continuously.
- Reset assertion takes effect asynchronously. Deassertion is assumed synchronous to `clk` by the surrounding system.

## Test plan
- Combinational, WIDTH=16: `a`=FFFF, `b`=0000.
  - `sel`=0 → `out`=FFFF.
  - `sel`=1 → `out`=0000.
- Combinational: `a`=ABCD, `b`=DCBA.
  - `sel`=0 → `out`=ABCD.
  - `sel`=1 → `out`=DCBA.
- Combinational: `a`=0101, `b`=5985.
  - `sel`=0 → `out`=0101.
  - `sel`=1 → `out`=5985.
- Register: `en`=1, `a`=1234, `sel`=0.
  - After one edge, `out_q`=1234.
  - Drop `en`, change `a` to 5678, clock 3 edges → `out_q` stays 1234.
- Select tracker: after reset, hold `sel`=0 for 2 edges, then raise `sel`=1 and hold it.
  - `sel_changed` is 0, then 1 for exactly one cycle, then 0.
- Asynchronous reset: with `out_q`=ABCD and `sel_changed`=1, assert `reset` between clock edges.
  - `out_q`=0000 and `sel_changed`=0 immediately.
  - `out` still equals the selected input.
